// File: rtl/int_ctrl_n_pkg.sv
// Shared constants for the interrupt controller and the instruction decoder:
// default vector layout, eret encoding and CP0 cause codes.
package int_pkg;

    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0800;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

    // eret is COP0 with the CO bit set and this funct field
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] FUNCT_ERET = 6'h18;

    localparam logic [4:0] CAUSE_INT  = 5'h00;
    localparam logic [4:0] CAUSE_SYS  = 5'h08;
    localparam logic [4:0] CAUSE_BP   = 5'h09;
    localparam logic [4:0] CAUSE_RI   = 5'h0a;
    localparam logic [4:0] CAUSE_OV   = 5'h0c;

    // Handler address of source idx, truncated to 32 bits
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [31:0] idx);
        logic [31:0] off;
        off = 32'(stride * idx);
        return 32'(base + off);
    endfunction

endpackage

// File: rtl/int_ctrl_n_prio_enc.sv
// Lowest-index-wins priority encoder: valid plus index of the lowest set bit.
module prio_enc_n #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/int_ctrl_n.sv
// Prioritised, optionally nesting interrupt controller with an EPC stack;
// drives the next-PC mux with int_take/int_vec and eret_take/eret_pc.
module int_ctrl_n
    import int_pkg::*;
#(
    parameter int unsigned N_SRC      = 4,
    parameter int unsigned AW         = 32,
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
    parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF,
    parameter bit          NESTED     = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_SRC-1:0]                  irq_req,
    input  logic                              cpu_run,
    input  logic [AW-1:0]                     pc_next,
    input  logic                              eret,
    input  logic                              ie_we,
    input  logic                              ie_din,
    input  logic                              mask_we,
    input  logic [N_SRC-1:0]                  mask_din,
    output logic                              int_take,
    output logic [AW-1:0]                     int_vec,
    output logic                              eret_take,
    output logic [AW-1:0]                     eret_pc,
    output logic [N_SRC-1:0]                  pending,
    output logic [N_SRC-1:0]                  in_service,
    output logic [$clog2(N_SRC+1)-1:0]        depth,
    output logic                              eret_err
);

    localparam int unsigned IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned DW = $clog2(N_SRC + 1);

    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] mask;
    logic             ie;
    logic             armed;
    logic [AW-1:0]    epc [N_SRC];

    logic             cand_valid;
    logic [IW-1:0]    cand_idx;
    logic             svc_valid;
    logic [IW-1:0]    svc_idx;
    logic             preempt_ok;
    logic [N_SRC-1:0] cand_oh;
    logic [N_SRC-1:0] svc_oh;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pending_nxt;
    logic [IW-1:0]    push_slot;
    logic [IW-1:0]    top_slot;

    prio_enc_n #(.N(N_SRC), .IW(IW)) u_cand (
        .req   (pending & mask),
        .valid (cand_valid),
        .idx   (cand_idx)
    );

    prio_enc_n #(.N(N_SRC), .IW(IW)) u_svc (
        .req   (in_service),
        .valid (svc_valid),
        .idx   (svc_idx)
    );

    // Next-PC control and pending update
    always_comb begin
        if (NESTED) preempt_ok = !svc_valid || (cand_idx < svc_idx);
        else        preempt_ok = !svc_valid;

        eret_take = cpu_run & eret & (depth != '0);
        eret_err  = cpu_run & eret & (depth == '0);
        int_take  = cpu_run & ie & cand_valid & preempt_ok & ~eret_take;

        cand_oh   = N_SRC'(1) << cand_idx;
        svc_oh    = N_SRC'(1) << svc_idx;
        push_slot = IW'(depth);
        top_slot  = IW'(depth - DW'(1));

        int_vec = '0;
        if (int_take) int_vec = AW'(vec_addr(VEC_BASE, VEC_STRIDE, 32'(cand_idx)));

        eret_pc = '0;
        if (depth != '0) eret_pc = epc[top_slot];

        // Lines are only sampled on the first edge after reset, so a level
        // held through reset is not mistaken for a new request.
        rise = armed ? (irq_req & ~irq_q) : '0;
        pending_nxt = (pending & ~(int_take ? cand_oh : '0)) | rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed      <= 1'b0;
            irq_q      <= '0;
            pending    <= '0;
            in_service <= '0;
            depth      <= '0;
            ie         <= 1'b0;
            mask       <= '0;
            for (int i = 0; i < int'(N_SRC); i++) epc[i] <= '0;
        end else begin
            armed   <= 1'b1;
            irq_q   <= irq_req;
            pending <= pending_nxt;
            if (ie_we)   ie   <= ie_din;
            if (mask_we) mask <= mask_din;
            if (eret_take) begin
                depth      <= depth - DW'(1);
                in_service <= in_service & ~svc_oh;
            end else if (int_take) begin
                epc[push_slot] <= pc_next;
                depth          <= depth + DW'(1);
                in_service     <= in_service | cand_oh;
            end
        end
    end

endmodule
